mac_accumulator: RTL and testbench

- Sequential multiply-accumulate stage placed directly downstream of the 16x16 signed Booth/Wallace `multiplier` module.
- Instantiates `multiplier` and registers its operands and 32-bit product.
- Accumulates the products of a frame of beats, delimited by `in_last`, into a wide signed accumulator.
- Presents the frame result on a valid/ready output with a 32-bit saturated view, a beat count and an overflow flag.

---
 rtl/mac_accumulator.sv | 138 +++++++++++++
 tb/tb_mac_accumulator.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_accumulator.sv
// mac_accumulator: frame-wise signed multiply-accumulate behind a radix-4 Booth / carry-save-tree multiplier
module multiplier (
    input  logic signed [15:0] a,
    input  logic signed [15:0] b,
    output logic signed [31:0] p
);
    logic [16:0] bx;
    logic [31:0] ax;
    logic [31:0] pp [8];
    logic [31:0] s [6];
    logic [31:0] c [6];
    function automatic logic [63:0] csa(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return {x ^ y ^ z, ((x & y) | (x & z) | (y & z)) << 1};
    endfunction
    assign bx = {b, 1'b0};
    assign ax = {{16{a[15]}}, a};
    // each overlapping bit triple of b selects 0, +-a or +-2a; all sums are taken mod 2^32
    for (genvar i = 0; i < 8; i++) begin : g_pp
        logic [2:0] t;
        logic [31:0] m;
        assign t = bx[2*i+:3];
        assign m = (t == 3'b011) ? ax << 1 :
                   (t == 3'b100) ? -(ax << 1) :
                   (t == 3'b001 || t == 3'b010) ? ax :
                   (t == 3'b101 || t == 3'b110) ? -ax : '0;
        assign pp[i] = m << (2 * i);
    end
    assign {s[0], c[0]} = csa(pp[0], pp[1], pp[2]);
    assign {s[1], c[1]} = csa(pp[3], pp[4], pp[5]);
    assign {s[2], c[2]} = csa(s[0], c[0], s[1]);
    assign {s[3], c[3]} = csa(c[1], pp[6], pp[7]);
    assign {s[4], c[4]} = csa(s[2], c[2], s[3]);
    assign {s[5], c[5]} = csa(s[4], c[4], c[3]);
    assign p = s[5] + c[5];
endmodule

module mac_accumulator #(
    parameter int ACC_W = 40,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [15:0]      in_a,
    input  logic signed [15:0]      in_b,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_acc,
    output logic [31:0]             out_sat,
    output logic [CNT_W-1:0]        out_cnt,
    output logic                    overflow
);
    logic stall, frame_end, add_ovf, flag, fits;
    logic v1, l1, v2, l2;
    logic signed [15:0] a1, b1;
    logic signed [31:0] prod, p2;
    logic signed [ACC_W-1:0] acc, pe, sum;
    logic [CNT_W-1:0] cnt, cnt_next;

    assign stall = out_valid & ~out_ready;
    assign in_ready = ~stall & ~clr;
    assign frame_end = v2 & l2 & ~stall;

    multiplier u_mul (.a(a1), .b(b1), .p(prod));

    assign pe = {{(ACC_W-32){p2[31]}}, p2};
    assign sum = acc + pe;
    assign add_ovf = (acc[ACC_W-1] == pe[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
    assign cnt_next = &cnt ? cnt : cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            l1 <= 1'b0;
            a1 <= '0;
            b1 <= '0;
            v2 <= 1'b0;
            l2 <= 1'b0;
            p2 <= '0;
        end else if (clr) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else if (!stall) begin
            v1 <= in_valid;
            l1 <= in_last;
            a1 <= in_a;
            b1 <= in_b;
            v2 <= v1;
            l2 <= l1;
            p2 <= prod;
        end
    end

    // the running state restarts at every frame end so the next frame starts from zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc  <= '0;
            cnt  <= '0;
            flag <= 1'b0;
        end else if (clr || frame_end) begin
            acc  <= '0;
            cnt  <= '0;
            flag <= 1'b0;
        end else if (v2 && !stall) begin
            acc  <= sum;
            cnt  <= cnt_next;
            flag <= flag | add_ovf;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_cnt   <= '0;
            overflow  <= 1'b0;
        end else if (clr) begin
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_cnt   <= '0;
            overflow  <= 1'b0;
        end else if (frame_end) begin
            out_valid <= 1'b1;
            out_acc   <= sum;
            out_cnt   <= cnt_next;
            overflow  <= flag | add_ovf;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // the value fits in 32 signed bits when all bits from 31 upward agree
    assign fits = &out_acc[ACC_W-1:31] | ~|out_acc[ACC_W-1:31];
    assign out_sat = fits ? out_acc[31:0] : out_acc[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: scoreboard bench driving a 40-bit and a 34-bit accumulator with identical beats
module tb_mac_accumulator;
    localparam int WW = 40;
    localparam int WN = 34;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic clk = 1'b0, rst = 1'b1, clr = 1'b0;
    logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic signed [15:0] in_a = '0, in_b = '0;
    logic in_ready, in_ready_n, out_valid, out_valid_n, overflow, overflow_n;
    logic signed [WW-1:0] out_acc;
    logic signed [WN-1:0] out_acc_n;
    logic [31:0] out_sat, out_sat_n;
    logic [7:0] out_cnt, out_cnt_n;

    typedef struct {
        longint acc_w;
        longint acc_n;
        int     cnt;
        bit     ov_w;
        bit     ov_n;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    longint run_w, run_n;
    bit f_w, f_n, rand_ready;
    int n_beats;
    int checks = 0, failures = 0;

    mac_accumulator #(.ACC_W(WW), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_acc(out_acc), .out_sat(out_sat),
        .out_cnt(out_cnt), .overflow(overflow)
    );

    mac_accumulator #(.ACC_W(WN), .CNT_W(8)) dut_n (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_n),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid_n),
        .out_ready(out_ready), .out_acc(out_acc_n), .out_sat(out_sat_n),
        .out_cnt(out_cnt_n), .overflow(overflow_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint wrap(input longint s, input int w);
        longint m = longint'(1) <<< w;
        if (s >= m / 2) return s - m;
        if (s < -(m / 2)) return s + m;
        return s;
    endfunction

    function automatic longint sat32(input longint v);
        if (v > SMAX) return 64'h7FFF_FFFF;
        if (v < SMIN) return 64'h8000_0000;
        return v & 64'hFFFF_FFFF;
    endfunction

    task automatic reset_model();
        run_w = 0;
        run_n = 0;
        f_w = 0;
        f_n = 0;
        n_beats = 0;
    endtask

    task automatic model_beat(input longint p, input bit last);
        f_w = f_w | (wrap(run_w + p, WW) != run_w + p);
        f_n = f_n | (wrap(run_n + p, WN) != run_n + p);
        run_w = wrap(run_w + p, WW);
        run_n = wrap(run_n + p, WN);
        n_beats++;
        if (last) begin
            exp_q.push_back('{run_w, run_n, (n_beats > 255) ? 255 : n_beats, f_w, f_n});
            reset_model();
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input int a, input int b, input bit last);
        bit done = 0;
        in_valid = 1'b1;
        in_a = 16'(a);
        in_b = 16'(b);
        in_last = last;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            done = in_ready;
            tick();
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        if (done) model_beat(longint'(a) * longint'(b), last);
        else begin
            checks++;
            failures++;
            $display("FAIL send_timeout: beat a=%0d b=%0d not accepted within 200 cycles", a, b);
        end
    endtask

    function automatic int rnd_op();
        int k = int'($urandom_range(0, 5));
        return (k == 0) ? -32768 : (k == 1) ? 32767 : int'(shortint'($urandom));
    endfunction

    always @(negedge clk) begin
        if (!rst && !clr && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_result: got out_acc=%0d expected no result", out_acc);
            end else begin
                e = exp_q.pop_front();
                chk("out_acc", longint'(out_acc), e.acc_w);
                chk("out_sat", longint'(out_sat), sat32(e.acc_w));
                chk("out_cnt", longint'(out_cnt), longint'(e.cnt));
                chk("overflow", longint'(overflow), longint'(e.ov_w));
                chk("out_valid_n", longint'(out_valid_n), 1);
                chk("in_ready_n", longint'(in_ready_n), longint'(in_ready));
                chk("out_acc_n", longint'(out_acc_n), e.acc_n);
                chk("out_sat_n", longint'(out_sat_n), sat32(e.acc_n));
                chk("out_cnt_n", longint'(out_cnt_n), longint'(e.cnt));
                chk("overflow_n", longint'(overflow_n), longint'(e.ov_n));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_model();
        rand_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_acc", longint'(out_acc), 0);
        rst = 1'b0;
        tick();
        chk("rst_out_sat", longint'(out_sat), 0);
        chk("rst_out_cnt", longint'(out_cnt), 0);
        chk("rst_overflow", longint'(overflow), 0);
        chk("rst_in_ready", longint'(in_ready), 1);
        out_ready = 1'b1;

        send(3, 4, 1);
        chk("lat_e0_valid", longint'(out_valid), 0);
        tick();
        chk("lat_e1_valid", longint'(out_valid), 0);
        tick();
        chk("lat_e2_valid", longint'(out_valid), 1);
        chk("lat_e2_acc", longint'(out_acc), 12);
        repeat (2) tick();

        send(100, -200, 0);
        repeat (3) tick();
        send(-7, 7, 1);
        repeat (4) tick();

        for (int i = 0; i < 4; i++) send(-32768, -32768, i == 3);
        repeat (4) tick();
        for (int i = 0; i < 8; i++) send(-32768, -32768, i == 7);
        repeat (4) tick();

        out_ready = 1'b0;
        send(2, 3, 1);
        send(5, 5, 1);
        repeat (2) tick();
        chk("stall_in_ready", longint'(in_ready), 0);
        chk("stall_out_valid", longint'(out_valid), 1);
        chk("stall_out_acc", longint'(out_acc), 6);
        out_ready = 1'b1;
        tick();
        chk("reload_valid", longint'(out_valid), 1);
        chk("reload_acc", longint'(out_acc), 25);
        repeat (3) tick();

        send(10, 10, 0);
        send(20, 20, 0);
        clr = 1'b1;
        in_valid = 1'b1;
        in_a = 16'sd7;
        in_b = 16'sd7;
        in_last = 1'b1;
        #1;
        chk("clr_in_ready", longint'(in_ready), 0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        exp_q.delete();
        reset_model();
        chk("clr_out_valid", longint'(out_valid), 0);
        chk("clr_out_acc", longint'(out_acc), 0);
        repeat (4) tick();
        chk("clr_no_result", longint'(out_valid), 0);
        send(1, 1, 1);
        repeat (4) tick();

        out_ready = 1'b0;
        send(9, 9, 1);
        send(4, 4, 0);
        repeat (2) tick();
        chk("pre_rst_valid", longint'(out_valid), 1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", longint'(out_valid), 0);
        chk("arst_out_acc", longint'(out_acc), 0);
        chk("arst_out_sat", longint'(out_sat), 0);
        chk("arst_out_cnt", longint'(out_cnt), 0);
        chk("arst_overflow", longint'(overflow), 0);
        exp_q.delete();
        reset_model();
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();
        chk("post_rst_idle", longint'(out_valid), 0);
        send(-1, 1, 1);
        repeat (4) tick();

        rand_ready = 1;
        for (int f = 0; f < 40; f++) begin
            int len = int'($urandom_range(1, 6));
            for (int j = 0; j < len; j++) begin
                send(rnd_op(), rnd_op(), j == len - 1);
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
            end
        end
        for (int i = 0; i < 300; i++) send(1, 1, i == 299);

        rand_ready = 0;
        out_ready = 1'b1;
        for (int t = 0; t < 100 && exp_q.size() > 0; t++) tick();
        chk("drain_queue", longint'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
